// File: rtl/fifo_wr_pack.sv
// Packs RATIO upstream beats of IN_WIDTH bits into one FIFO word, lane 0 in the LSBs.
// Optional FIFO_WR_PACK_FLUSH_EN: an accepted beat with in_last closes the word early.
module fifo_wr_pack #(
  parameter int IN_WIDTH  = 4,
  parameter int RATIO     = 4,
  parameter int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       Reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_WIDTH-1:0]        in_data,
  input  logic                       in_last,
  output logic                       push,
  output logic [OUT_WIDTH-1:0]       data_in,
  input  logic                       full,
  output logic [$clog2(RATIO)-1:0]   lane_idx,
  output logic                       busy
);

  localparam int LW = $clog2(RATIO);
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  logic [OUT_WIDTH-1:0] acc_p0;
  logic [LW-1:0]        lane_p0;
  logic [OUT_WIDTH-1:0] word_p1;
  logic                 vld_p1;

  logic                 at_last_lane;
  logic                 flush_hit;
  logic                 accept;
  logic                 complete;
  logic [OUT_WIDTH-1:0] acc_next;

  function automatic logic [OUT_WIDTH-1:0] insert_beat(
    input logic [OUT_WIDTH-1:0] acc,
    input logic [LW-1:0]        lane,
    input logic [IN_WIDTH-1:0]  beat
  );
    logic [OUT_WIDTH-1:0] r;
    r = acc;
    r[int'(lane) * IN_WIDTH +: IN_WIDTH] = beat;
    return r;
  endfunction

`ifdef FIFO_WR_PACK_FLUSH_EN
  assign flush_hit = in_last;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign flush_hit      = 1'b0;
`endif

  assign at_last_lane = (lane_p0 == LAST_LANE);
  assign push         = vld_p1 && !full;
  // A beat that would close a word must wait while the previous word is still stuck.
  assign in_ready     = !((at_last_lane || flush_hit) && vld_p1 && !push);
  assign accept       = in_valid && in_ready;
  assign complete     = accept && (at_last_lane || flush_hit);

  assign data_in  = word_p1;
  assign lane_idx = lane_p0;
  assign busy     = vld_p1 || (lane_p0 != '0);

  always_comb begin
    acc_next = insert_beat(acc_p0, lane_p0, in_data);
  end

  // p0: lane accumulator -> p1: output word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0  <= '0;
      lane_p0 <= '0;
      word_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (Reset) begin
      acc_p0  <= '0;
      lane_p0 <= '0;
      word_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      if (push) begin
        vld_p1 <= 1'b0;
      end
      if (accept) begin
        if (complete) begin
          word_p1 <= acc_next;
          vld_p1  <= 1'b1;
          acc_p0  <= '0;
          lane_p0 <= '0;
        end else begin
          acc_p0  <= acc_next;
          lane_p0 <= lane_p0 + LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_pack.sv
// Bench for fifo_wr_pack: directed vector table, hand-written corner sequences, and a
// randomized run against a queue-based reference model.
module tb_fifo_wr_pack;

  localparam int IW = 4;
  localparam int R  = 4;
  localparam int OW = IW * R;
`ifdef FIFO_WR_PACK_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          Reset;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          push;
  logic [OW-1:0] data_in;
  logic          full;
  logic [1:0]    lane_idx;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_wr_pack #(.IN_WIDTH(IW), .RATIO(R)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Reset    (Reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .push     (push),
    .data_in  (data_in),
    .full     (full),
    .lane_idx (lane_idx),
    .busy     (busy)
  );

  typedef struct {
    logic          v;
    logic [IW-1:0] d;
    logic          f;
    logic          r;
    logic          e_rdy;
    logic          e_push;
    logic [OW-1:0] e_data;
    logic          chk_d;
    logic [1:0]    e_lane;
    logic          e_busy;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic v, input logic [IW-1:0] d, input logic f,
                              input logic r, input logic e_rdy, input logic e_push,
                              input logic [OW-1:0] e_data, input logic chk_d,
                              input logic [1:0] e_lane, input logic e_busy);
    vec_t t;
    t.v = v; t.d = d; t.f = f; t.r = r;
    t.e_rdy = e_rdy; t.e_push = e_push; t.e_data = e_data; t.chk_d = chk_d;
    t.e_lane = e_lane; t.e_busy = e_busy;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic v, input logic [IW-1:0] d, input logic l,
                       input logic f, input logic r);
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; full = f; Reset = r;
    #1;
  endtask

  // Reference model: beats of the word being built, plus the pending output word.
  logic [IW-1:0] m_cur[$];
  logic          m_ov;
  logic [OW-1:0] m_word;

  function automatic logic [OW-1:0] pack_beats(input logic [IW-1:0] q[$]);
    logic [OW-1:0] w;
    w = '0;
    for (int i = 0; i < q.size(); i++) w = w | (OW'(q[i]) << (i * IW));
    return w;
  endfunction

  initial begin
    rst_n = 1'b1; Reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; full = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_push", push, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_data", data_in, 0);
    chk("rst_lane", lane_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Four beats -> one word; then eight continuous beats -> two words four cycles apart.
    tbl[0]  = mk(1, 4'h1, 0, 0, 1, 0, 16'h0000, 1, 0, 0);
    tbl[1]  = mk(1, 4'h2, 0, 0, 1, 0, 16'h0000, 0, 1, 1);
    tbl[2]  = mk(1, 4'h3, 0, 0, 1, 0, 16'h0000, 0, 2, 1);
    tbl[3]  = mk(1, 4'h4, 0, 0, 1, 0, 16'h0000, 0, 3, 1);
    tbl[4]  = mk(0, 4'h0, 0, 0, 1, 1, 16'h4321, 1, 0, 1);
    tbl[5]  = mk(0, 4'h0, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
    tbl[6]  = mk(1, 4'h0, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
    tbl[7]  = mk(1, 4'h1, 0, 0, 1, 0, 16'h0000, 0, 1, 1);
    tbl[8]  = mk(1, 4'h2, 0, 0, 1, 0, 16'h0000, 0, 2, 1);
    tbl[9]  = mk(1, 4'h3, 0, 0, 1, 0, 16'h0000, 0, 3, 1);
    tbl[10] = mk(1, 4'h4, 0, 0, 1, 1, 16'h3210, 1, 0, 1);
    tbl[11] = mk(1, 4'h5, 0, 0, 1, 0, 16'h0000, 0, 1, 1);
    tbl[12] = mk(1, 4'h6, 0, 0, 1, 0, 16'h0000, 0, 2, 1);
    tbl[13] = mk(1, 4'h7, 0, 0, 1, 0, 16'h0000, 0, 3, 1);
    tbl[14] = mk(0, 4'h0, 0, 0, 1, 1, 16'h7654, 1, 0, 1);
    tbl[15] = mk(0, 4'h0, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      drive(tbl[k].v, tbl[k].d, 1'b0, tbl[k].f, tbl[k].r);
      chk($sformatf("vec%0d_ready", k), in_ready, tbl[k].e_rdy);
      chk($sformatf("vec%0d_push", k), push, tbl[k].e_push);
      chk($sformatf("vec%0d_lane", k), lane_idx, tbl[k].e_lane);
      chk($sformatf("vec%0d_busy", k), busy, tbl[k].e_busy);
      if (tbl[k].chk_d) chk($sformatf("vec%0d_data", k), data_in, tbl[k].e_data);
    end

    // Full held: seven beats accepted, eighth stalls until the word drains.
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      drive(1, IW'(i), 0, 1, 0);
      chk($sformatf("full_beat%0d_ready", i), in_ready, 1);
      chk($sformatf("full_beat%0d_push", i), push, 0);
      chk($sformatf("full_beat%0d_lane", i), lane_idx, i % R);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'h7, 0, 1, 0);
      chk("full_stall_ready", in_ready, 0);
      chk("full_stall_push", push, 0);
      chk("full_stall_data", data_in, 16'h3210);
      chk("full_stall_lane", lane_idx, 3);
    end
    drive(1, 4'h7, 0, 0, 0);
    chk("release_push", push, 1);
    chk("release_data", data_in, 16'h3210);
    chk("release_ready", in_ready, 1);
    drive(0, 0, 0, 0, 0);
    chk("release2_push", push, 1);
    chk("release2_data", data_in, 16'h7654);
    chk("release2_lane", lane_idx, 0);
    drive(0, 0, 0, 0, 0);
    chk("release3_busy", busy, 0);

    // Synchronous clear of a partial word.
    drive(1, 4'h9, 0, 0, 0);
    drive(1, 4'hA, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    chk("sclr_pre_lane", lane_idx, 2);
    chk("sclr_pre_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      chk("sclr_lane", lane_idx, 0);
      chk("sclr_busy", busy, 0);
      chk("sclr_push", push, 0);
    end

    // Asynchronous reset while a word is held behind full.
    for (int i = 0; i < 4; i++) drive(1, IW'(i + 1), 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("arst_pre_busy", busy, 1);
    chk("arst_pre_push", push, 0);
    chk("arst_pre_data", data_in, 16'h4321);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_push", push, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_data", data_in, 0);
    full = 1'b0;
    #1;
    chk("arst_nofull_push", push, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef FIFO_WR_PACK_FLUSH_EN
    drive(1, 4'h5, 0, 0, 0);
    drive(1, 4'h6, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("flush_push", push, 1);
    chk("flush_data", data_in, 16'h0065);
    chk("flush_lane", lane_idx, 0);
`endif

    // Randomized run against the model.
    drive(0, 0, 0, 0, 1);
    m_cur.delete();
    m_ov = 1'b0;
    m_word = '0;
    for (int c = 0; c < 3000; c++) begin
      logic          v, l, f, r, m_push, m_rdy;
      logic [IW-1:0] d;
      v = ($urandom_range(0, 3) != 0);
      d = IW'($urandom);
      l = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 63) == 0);
      drive(v, d, l, f, r);
      m_push = m_ov && !f;
      m_rdy  = !(((m_cur.size() == R - 1) || (FLUSH && l)) && m_ov && !m_push);
      chk("rnd_ready", in_ready, m_rdy);
      chk("rnd_push", push, m_push);
      chk("rnd_lane", lane_idx, m_cur.size());
      chk("rnd_busy", busy, m_ov || (m_cur.size() != 0));
      if (m_ov) chk("rnd_data", data_in, m_word);
      if (r) begin
        m_cur.delete();
        m_ov = 1'b0;
      end else begin
        if (m_push) m_ov = 1'b0;
        if (v && m_rdy) begin
          m_cur.push_back(d);
          if (m_cur.size() == R || (FLUSH && l)) begin
            m_word = pack_beats(m_cur);
            m_ov = 1'b1;
            m_cur.delete();
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
